// File: rtl/alu_regfile_ctrl.sv
// Register-mapped ALU controller: host bus, IDLE/EXEC/MUL/DONE sequencer, registered read path.
// Optional shift-add multiplier for opcode 8 is built only when ALU_MUL_EN is defined.
module alu_regfile_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr_enb,
  input  logic              rd_enb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              op_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] A_RESULT    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OPA       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OPB       = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_OPCODE    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RESULT_HI = ADDR_W'(5);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [3:0]          opcode_q, opcode_d, lat_op_q, lat_op_d;
  logic [DATA_W-1:0]   lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [DATA_W-1:0]   result_q, result_d, result_hi_q, result_hi_d;
  logic                done_stk_q, done_stk_d, carry_q, carry_d, zero_q, zero_d;
  logic                illegal_q, illegal_d, wr_err_q, wr_err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;

  logic                wr_s, rd_s;
  logic [DATA_W-1:0]   rd_mux_s, alu_res_s;
  logic                alu_carry_s, alu_legal_s, alu_cmp_s;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W) + 1;
  logic [2*DATA_W-1:0] prod_q, prod_d, prod_step_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // One shift-add step: low half holds the remaining multiplier bits, high half accumulates.
  function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] p,
                                                    input logic [DATA_W-1:0]   m);
    logic [DATA_W:0] hi;
    hi = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : {(DATA_W+1){1'b0}});
    return {hi, p[DATA_W-1:1]};
  endfunction

  assign prod_step_s = mul_step(prod_q, lat_b_q);
`endif

  assign wr_s = cs & wr_enb;
  assign rd_s = cs & rd_enb & ~wr_enb;

  always_comb begin
    alu_res_s   = {DATA_W{1'b0}};
    alu_carry_s = 1'b0;
    alu_legal_s = 1'b1;
    alu_cmp_s   = 1'b0;
    case (lat_op_q)
      4'd0: {alu_carry_s, alu_res_s} = {1'b0, lat_a_q} + {1'b0, lat_b_q};
      4'd1: {alu_carry_s, alu_res_s} = {1'b0, lat_a_q} - {1'b0, lat_b_q};
      4'd2: alu_res_s = lat_a_q & lat_b_q;
      4'd3: alu_res_s = lat_a_q | lat_b_q;
      4'd4: alu_res_s = lat_a_q ^ lat_b_q;
      4'd5: alu_res_s = ~lat_a_q;
      4'd6: begin
        alu_res_s   = {lat_a_q[DATA_W-2:0], 1'b0};
        alu_carry_s = lat_a_q[DATA_W-1];
      end
      4'd7: begin
        alu_res_s   = {1'b0, lat_a_q[DATA_W-1:1]};
        alu_carry_s = lat_a_q[0];
      end
      4'd9: begin
        alu_cmp_s   = 1'b1;
        alu_res_s   = result_q;
        alu_carry_s = (lat_a_q < lat_b_q);
      end
      default: alu_legal_s = 1'b0;
    endcase
  end

  always_comb begin
    case (addr)
      A_RESULT:    rd_mux_s = result_q;
      A_OPA:       rd_mux_s = opa_q;
      A_OPB:       rd_mux_s = opb_q;
      A_OPCODE:    rd_mux_s = {{(DATA_W-4){1'b0}}, opcode_q};
      A_STATUS:    rd_mux_s = {{(DATA_W-6){1'b0}}, wr_err_q, illegal_q, zero_q,
                               carry_q, done_stk_q, busy_q};
      A_RESULT_HI: rd_mux_s = result_hi_q;
      default:     rd_mux_s = {DATA_W{1'b0}};
    endcase
  end

  // Bus writes first, then the sequencer, so status set events win over same-cycle W1C.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opcode_d    = opcode_q;
    lat_op_d    = lat_op_q;
    lat_a_d     = lat_a_q;
    lat_b_d     = lat_b_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    done_stk_d  = done_stk_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    wr_err_d    = wr_err_q;
`ifdef ALU_MUL_EN
    prod_d      = prod_q;
    cnt_d       = cnt_q;
`endif

    if (wr_s) begin
      case (addr)
        A_OPA:    if (busy_q) wr_err_d = 1'b1; else opa_d = wr_data;
        A_OPB:    if (busy_q) wr_err_d = 1'b1; else opb_d = wr_data;
        A_OPCODE: if (busy_q) wr_err_d = 1'b1; else opcode_d = wr_data[3:0];
        A_STATUS: begin
          if (wr_data[1]) done_stk_d = 1'b0;
          if (wr_data[4]) illegal_d  = 1'b0;
          if (wr_data[5]) wr_err_d   = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          lat_a_d  = opa_q;
          lat_b_d  = opb_q;
          lat_op_d = opcode_q;
          state_d  = ST_EXEC;
`ifdef ALU_MUL_EN
          if (opcode_q == 4'd8) begin
            prod_d  = {{DATA_W{1'b0}}, opa_q};
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_MUL;
          end
`endif
        end
      end
      ST_EXEC: begin
        if (alu_legal_s) begin
          result_d = alu_res_s;
          carry_d  = alu_carry_s;
          if (alu_cmp_s) begin
            zero_d = (lat_a_q == lat_b_q);
          end else begin
            zero_d      = (alu_res_s == {DATA_W{1'b0}});
            result_hi_d = {DATA_W{1'b0}};
          end
        end else begin
          illegal_d = 1'b1;
        end
        done_stk_d = 1'b1;
        state_d    = ST_DONE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        prod_d = prod_step_s;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          result_d    = prod_step_s[DATA_W-1:0];
          result_hi_d = prod_step_s[2*DATA_W-1:DATA_W];
          carry_d     = (prod_step_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
          zero_d      = (prod_step_s[DATA_W-1:0] == {DATA_W{1'b0}});
          done_stk_d  = 1'b1;
          state_d     = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_data_d  = rd_s ? rd_mux_s : rd_data_q;
    rd_valid_d = rd_s;
    busy_d     = (state_d == ST_EXEC) || (state_d == ST_MUL);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      opa_q       <= {DATA_W{1'b0}};
      opb_q       <= {DATA_W{1'b0}};
      opcode_q    <= 4'd0;
      lat_op_q    <= 4'd0;
      lat_a_q     <= {DATA_W{1'b0}};
      lat_b_q     <= {DATA_W{1'b0}};
      result_q    <= {DATA_W{1'b0}};
      result_hi_q <= {DATA_W{1'b0}};
      done_stk_q  <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_data_q   <= {DATA_W{1'b0}};
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q      <= {(2*DATA_W){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opcode_q    <= opcode_d;
      lat_op_q    <= lat_op_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      done_stk_q  <= done_stk_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      wr_err_q    <= wr_err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ALU_MUL_EN
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Self-checking bench for alu_regfile_ctrl (DATA_W=8): vector table, corner sequences,
// and random ops checked against an integer-arithmetic model of the register file.
module tb_alu_regfile_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cs, wr_enb, rd_enb, op_start;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, busy, done;

  always #5 clk = ~clk;

  alu_regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr_enb(wr_enb), .rd_enb(rd_enb), .addr(addr),
    .wr_data(wr_data), .op_start(op_start), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference state, plain integers.
  int m_opa, m_opb, m_opc, m_res, m_hi;
  bit m_dstk, m_c, m_z, m_ill, m_werr;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, res;
    logic       c, z;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_opa = 0; m_opb = 0; m_opc = 0; m_res = 0; m_hi = 0;
    m_dstk = 0; m_c = 0; m_z = 0; m_ill = 0; m_werr = 0;
  endfunction

  function automatic void model_set(input int r, input bit c);
    m_res = r & 255;
    m_hi  = 0;
    m_c   = c;
    m_z   = (m_res == 0);
  endfunction

  function automatic void model_op();
    int a = m_opa;
    int b = m_opb;
    int p;
    m_dstk = 1'b1;
    case (m_opc)
      0: model_set(a + b, (a + b) > 255);
      1: model_set(a - b, a < b);
      2: model_set(a & b, 1'b0);
      3: model_set(a | b, 1'b0);
      4: model_set(a ^ b, 1'b0);
      5: model_set(~a, 1'b0);
      6: model_set(a * 2, a >= 128);
      7: model_set(a / 2, (a % 2) == 1);
      8: begin
        if (MUL_ON) begin
          p = a * b;
          m_res = p % 256;
          m_hi  = p / 256;
          m_c   = (m_hi != 0);
          m_z   = (m_res == 0);
        end else begin
          m_ill = 1'b1;
        end
      end
      9: begin
        m_z = (a == b);
        m_c = (a < b);
      end
      default: m_ill = 1'b1;
    endcase
  endfunction

  function automatic int exp_status();
    return (int'(m_werr) << 5) | (int'(m_ill) << 4) | (int'(m_z) << 3) |
           (int'(m_c) << 2) | (int'(m_dstk) << 1);
  endfunction

  // Tasks start just after a falling edge and end on one.
  task automatic bus_write(input int a, input int d);
    cs = 1'b1; wr_enb = 1'b1; addr = AW'(a); wr_data = DW'(d);
    @(negedge clk);
    cs = 1'b0; wr_enb = 1'b0;
    case (a)
      1: m_opa = d & 255;
      2: m_opb = d & 255;
      3: m_opc = d & 15;
      4: begin
        if (d & 2)  m_dstk = 1'b0;
        if (d & 16) m_ill  = 1'b0;
        if (d & 32) m_werr = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic read_chk(input string name, input int a, input int exp);
    cs = 1'b1; rd_enb = 1'b1; addr = AW'(a);
    @(negedge clk);
    cs = 1'b0; rd_enb = 1'b0;
    chk({name, "_valid"}, rd_valid, 1);
    chk(name, rd_data, exp);
  endtask

  task automatic run_op(input int exp_len);
    int n = 0;
    bit early = 1'b0;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    while (busy && n < 40) begin
      if (done) early = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, exp_len);
    chk("done_during_busy", early, 0);
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    model_op();
  endtask

  task automatic check_all_regs(input string tag);
    read_chk({tag, "_result"}, 0, m_res);
    read_chk({tag, "_result_hi"}, 5, m_hi);
    read_chk({tag, "_status"}, 4, exp_status());
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    vecs[0]  = '{4'd0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
    vecs[1]  = '{4'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{4'd9, 8'h03, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{4'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[4]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[5]  = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{4'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{4'd5, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{4'd6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[9]  = '{4'd7, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0};
    vecs[10] = '{4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{4'd9, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};

    rst = 1'b1; cs = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0; op_start = 1'b0;
    addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int a = 0; a < 8; a++) read_chk("rst_reg", a, 0);

    // Vector table: expectations written out by hand.
    for (int i = 0; i < 12; i++) begin
      bus_write(1, vecs[i].a);
      bus_write(2, vecs[i].b);
      bus_write(3, vecs[i].op);
      run_op(1);
      read_chk("vec_result", 0, vecs[i].res);
      read_chk("vec_result_hi", 5, 0);
      read_chk("vec_status", 4, {vecs[i].z, vecs[i].c, 2'b10});
    end

`ifdef ALU_MUL_EN
    bus_write(1, 8'hFF); bus_write(2, 8'hFF); bus_write(3, 8);
    run_op(DW);
    read_chk("mul_result", 0, 8'h01);
    read_chk("mul_result_hi", 5, 8'hFE);
    read_chk("mul_status", 4, 8'h06);
`endif

    // Operand write and op_start while busy are both dropped.
    bus_write(1, 8'hFF); bus_write(2, 8'hFF); bus_write(3, MUL_ON ? 8 : 0);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (MUL_ON) @(negedge clk);
    cs = 1'b1; wr_enb = 1'b1; addr = AW'(1); wr_data = 8'h12; op_start = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr_enb = 1'b0; op_start = 1'b0;
    n = 0;
    while (!done && n < 40) begin n++; @(negedge clk); end
    chk("busy_wr_done", done, 1);
    @(negedge clk);
    chk("no_restart", busy, 0);
    m_werr = 1'b1;
    model_op();
    read_chk("busy_wr_opa", 1, 8'hFF);
    check_all_regs("busy_wr");
    bus_write(4, 8'h20);
    read_chk("wr_err_clear", 4, exp_status());

    // Illegal opcodes leave the result state alone.
    bus_write(3, 8'h1F);
    read_chk("opcode_low4", 3, 8'h0F);
    run_op(1);
    check_all_regs("illegal_f");
    bus_write(4, 8'h10);
`ifndef ALU_MUL_EN
    bus_write(3, 8);
    run_op(1);
    check_all_regs("illegal_8");
    bus_write(4, 8'h10);
`endif
    read_chk("unmapped6", 6, 0);
    read_chk("unmapped7", 7, 0);

    // Write and read together: write lands, no read, rd_data held.
    cs = 1'b1; wr_enb = 1'b1; rd_enb = 1'b1; addr = AW'(2); wr_data = 8'h5A;
    @(negedge clk);
    cs = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
    m_opb = 8'h5A;
    chk("wr_rd_no_valid", rd_valid, 0);
    chk("wr_rd_hold", rd_data, 0);
    read_chk("wr_rd_opb", 2, 8'h5A);
    @(negedge clk);
    chk("idle_valid_low", rd_valid, 0);
    chk("idle_rd_hold", rd_data, 8'h5A);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 15);
      bus_write(1, $urandom_range(0, 255));
      bus_write(2, $urandom_range(0, 255));
      bus_write(3, op);
      run_op((op == 8 && MUL_ON) ? DW : 1);
      check_all_regs("rand");
      bus_write(4, 8'h32);
    end

    // Reset in the middle of an operation.
    bus_write(1, 8'hFF); bus_write(2, 8'hFF); bus_write(3, MUL_ON ? 8 : 0);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    if (MUL_ON) repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("mid_rst_no_done", seen, 0);
    for (int a = 0; a < 6; a++) read_chk("mid_rst_reg", a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
